// File: rtl/ad_trig_capture.sv
// ad_trig_capture: single-shot pre/post-trigger capture of two ADC channels into circular buffers.
// Optional timeout auto-trigger enabled by defining AD_TRIG_AUTO_EN.
module ad_trig_capture #(
    parameter int DW           = 12,
    parameter int AW           = 10,
    parameter int PRE_DEPTH    = 256,
    parameter int AUTO_TIMEOUT = 65535
) (
    input  logic          clk_in,
    input  logic          rst_n,
    input  logic [DW-1:0] sample_ch1,
    input  logic [DW-1:0] sample_ch2,
    input  logic          sample_valid,
    input  logic          arm,
    input  logic          trig_sel,
    input  logic          trig_edge,
    input  logic [DW-1:0] trig_level,
    output logic          busy,
    output logic          done,
    output logic          auto_trig,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data_ch1,
    output logic [DW-1:0] rd_data_ch2,
    output logic [AW-1:0] trig_index
);
    localparam int N = 1 << AW;
    localparam logic [AW-1:0] PRE_A     = AW'(PRE_DEPTH);
    localparam logic [AW-1:0] PRE_LAST  = AW'(PRE_DEPTH - 1);
    localparam logic [AW-1:0] POST_LOAD = AW'(N - PRE_DEPTH - 1);

    typedef enum logic [2:0] {S_IDLE, S_PRE, S_WAIT, S_POST, S_DONE} state_t;

    logic [DW-1:0] ram_ch1 [N];
    logic [DW-1:0] ram_ch2 [N];
    state_t        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, cnt_q, cnt_d, trig_addr_q, trig_addr_d;
    logic [DW-1:0] prev_q, prev_d, cur;
    logic          prev_ok_q, prev_ok_d, busy_q, busy_d, done_q, done_d;
    logic [DW-1:0] rd1_q, rd1_d, rd2_q, rd2_d;
    logic          we, hit, rise, fall, timeout;
    logic [AW-1:0] phys;

`ifdef AD_TRIG_AUTO_EN
    localparam int TW = $clog2(AUTO_TIMEOUT + 1);
    logic [TW-1:0] wcnt_q, wcnt_d;
    logic          auto_q, auto_d;
    assign timeout   = (wcnt_q == TW'(AUTO_TIMEOUT - 1));
    assign auto_trig = auto_q;
`else
    assign timeout   = 1'b0;
    assign auto_trig = 1'b0;
`endif

    always_comb begin
        cur  = trig_sel ? sample_ch2 : sample_ch1;
        we   = sample_valid && (state_q inside {S_PRE, S_WAIT, S_POST});
        rise = ($signed(prev_q) < $signed(trig_level)) && ($signed(cur) >= $signed(trig_level));
        fall = ($signed(prev_q) > $signed(trig_level)) && ($signed(cur) <= $signed(trig_level));
        hit  = prev_ok_q && (trig_edge ? fall : rise);
        state_d     = state_q;
        wr_ptr_d    = we ? wr_ptr_q + 1'b1 : wr_ptr_q;
        prev_d      = we ? cur : prev_q;
        prev_ok_d   = we ? 1'b1 : prev_ok_q;
        cnt_d       = cnt_q;
        trig_addr_d = trig_addr_q;
`ifdef AD_TRIG_AUTO_EN
        wcnt_d = wcnt_q;
        auto_d = auto_q;
`endif
        unique case (state_q)
            S_IDLE, S_DONE: if (arm) begin
                state_d   = S_PRE;
                cnt_d     = '0;
                prev_ok_d = 1'b0;
`ifdef AD_TRIG_AUTO_EN
                wcnt_d = '0;
                auto_d = 1'b0;
`endif
            end
            S_PRE: if (we) begin
                cnt_d   = cnt_q + 1'b1;
                state_d = (cnt_q == PRE_LAST) ? S_WAIT : S_PRE;
            end
            S_WAIT: if (we) begin
`ifdef AD_TRIG_AUTO_EN
                wcnt_d = wcnt_q + 1'b1;
`endif
                // The crossing (or timed-out) sample itself is the trigger sample
                if (hit || timeout) begin
                    trig_addr_d = wr_ptr_q;
                    cnt_d       = POST_LOAD;
                    state_d     = (POST_LOAD == '0) ? S_DONE : S_POST;
`ifdef AD_TRIG_AUTO_EN
                    auto_d = !hit;
`endif
                end
            end
            S_POST: if (we) begin
                cnt_d   = cnt_q - 1'b1;
                state_d = (cnt_q == AW'(1)) ? S_DONE : S_POST;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = state_d inside {S_PRE, S_WAIT, S_POST};
        done_d = (state_d == S_DONE);
        phys   = trig_addr_q - PRE_A + rd_addr;
        rd1_d  = ram_ch1[phys];
        rd2_d  = ram_ch2[phys];
    end

    always_ff @(posedge clk_in) begin
        if (we) begin
            ram_ch1[wr_ptr_q] <= sample_ch1;
            ram_ch2[wr_ptr_q] <= sample_ch2;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            cnt_q       <= '0;
            trig_addr_q <= '0;
            prev_q      <= '0;
            prev_ok_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd1_q       <= '0;
            rd2_q       <= '0;
`ifdef AD_TRIG_AUTO_EN
            wcnt_q <= '0;
            auto_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            cnt_q       <= cnt_d;
            trig_addr_q <= trig_addr_d;
            prev_q      <= prev_d;
            prev_ok_q   <= prev_ok_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rd1_q       <= rd1_d;
            rd2_q       <= rd2_d;
`ifdef AD_TRIG_AUTO_EN
            wcnt_q <= wcnt_d;
            auto_q <= auto_d;
`endif
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign rd_data_ch1 = rd1_q;
    assign rd_data_ch2 = rd2_q;
    assign trig_index  = PRE_A;
endmodule

// File: tb/tb_ad_trig_capture.sv
// tb_ad_trig_capture: directed and randomized capture checks against a sample-history model.
module tb_ad_trig_capture;
    localparam int DW = 12, AW = 4, PRE = 4, N = 16, ATO = 20;

    logic clk_in = 1'b0, rst_n = 1'b0;
    logic [DW-1:0] ch1 = '0, ch2 = '0, lvl = '0;
    logic valid = 1'b0, arm = 1'b0, sel = 1'b0, edg = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic busy, done, auto_trig;
    logic [DW-1:0] rd1, rd2;
    logic [AW-1:0] trig_index;

    ad_trig_capture #(.DW(DW), .AW(AW), .PRE_DEPTH(PRE), .AUTO_TIMEOUT(ATO)) dut (
        .clk_in(clk_in), .rst_n(rst_n), .sample_ch1(ch1), .sample_ch2(ch2),
        .sample_valid(valid), .arm(arm), .trig_sel(sel), .trig_edge(edg),
        .trig_level(lvl), .busy(busy), .done(done), .auto_trig(auto_trig),
        .rd_addr(rd_addr), .rd_data_ch1(rd1), .rd_data_ch2(rd2), .trig_index(trig_index)
    );

    always #5 clk_in = ~clk_in;

    int n_chk = 0, n_fail = 0;
    task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Model: the capture is the list of valid samples since arm; trigger and window follow from it
    bit m_act = 0, m_done = 0, m_auto = 0, rd_ok = 0;
    int m_k = -1;
    logic signed [DW-1:0] q1[$], q2[$];
    logic signed [DW-1:0] w1[N], w2[N], g1[N], g2[N];
    logic signed [DW-1:0] rd_e1 = '0, rd_e2 = '0;

    function automatic bit crosses(input logic signed [DW-1:0] p, input logic signed [DW-1:0] c);
        logic signed [DW-1:0] l;
        l = lvl;
        return edg ? (p > l && c <= l) : (p < l && c >= l);
    endfunction

    always @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            m_act = 0; m_done = 0; m_auto = 0; rd_ok = 0;
        end else begin
            rd_ok = m_done;
            if (m_done) begin rd_e1 = w1[rd_addr]; rd_e2 = w2[rd_addr]; end
            if (!m_act) begin
                if (arm) begin
                    m_act = 1; m_done = 0; m_auto = 0; m_k = -1;
                    q1.delete(); q2.delete();
                end
            end else if (valid) begin
                int idx;
                q1.push_back(ch1); q2.push_back(ch2);
                idx = q1.size() - 1;
                if (m_k < 0 && idx >= PRE) begin
                    if (sel ? crosses(q2[idx-1], q2[idx]) : crosses(q1[idx-1], q1[idx])) m_k = idx;
`ifdef AD_TRIG_AUTO_EN
                    else if (idx - PRE + 1 == ATO) begin m_k = idx; m_auto = 1; end
`endif
                end
                if (m_k >= 0 && q1.size() == m_k + N - PRE) begin
                    m_act = 0; m_done = 1;
                    for (int j = 0; j < N; j++) begin w1[j] = q1[m_k-PRE+j]; w2[j] = q2[m_k-PRE+j]; end
                end
            end
        end
    end

    always @(negedge clk_in) begin
        if (rst_n) begin
            check("busy", busy, m_act);
            check("done", done, m_done);
`ifdef AD_TRIG_AUTO_EN
            check("auto_trig", auto_trig, m_auto);
`else
            check("auto_trig", auto_trig, 0);
`endif
            check("trig_index", trig_index, PRE);
            if (rd_ok) begin
                check("rd_ch1", $signed(rd1), rd_e1);
                check("rd_ch2", $signed(rd2), rd_e2);
            end
        end
    end

    task automatic drive(input bit v, input int c1, input int c2, input bit a);
        @(negedge clk_in);
        valid = v; ch1 = DW'(c1); ch2 = DW'(c2); arm = a;
    endtask

    task automatic setup(input bit s, input bit e, input int l);
        @(negedge clk_in);
        sel = s; edg = e; lvl = DW'(l); valid = 0; arm = 0;
    endtask

    task automatic sweep();
        for (int a = 0; a < N; a++) begin
            @(negedge clk_in);
            valid = 0; arm = 0; rd_addr = AW'(a);
            @(posedge clk_in); #1;
            g1[a] = rd1; g2[a] = rd2;
        end
    endtask

    task automatic ramp_capture();
        int k = 0;
        setup(0, 0, 0);
        drive(1, -9, 99, 1);
        do begin drive(1, -8 + k, 100 + k, 0); k++; end while (!m_done && k < 200);
        check("ramp_done", done, 1);
        check("ramp_trig_pos", m_k, 8);
        sweep();
        for (int a = 0; a < N; a++) begin
            check("ramp_rd_ch1", g1[a], -4 + a);
            check("ramp_rd_ch2", g2[a], 104 + a);
        end
    endtask

    initial begin
        int k;
        #3;
        check("rst_busy", busy, 0); check("rst_done", done, 0); check("rst_auto", auto_trig, 0);
        check("rst_rd1", rd1, 0); check("rst_rd2", rd2, 0);
        @(negedge clk_in); #2 rst_n = 1;
        for (int i = 0; i < 20; i++) drive(1, i - 10, i, 0);
        check("idle_busy", busy, 0); check("idle_done", done, 0);

        ramp_capture();

        // falling edge on ch2, ch1 carries the sample number
        setup(1, 1, 100);
        drive(1, 0, 0, 1);
        k = 0;
        do begin drive(1, k, k < 6 ? 200 : (k == 6 ? 50 : 30), 0); k++; end while (!m_done && k < 200);
        check("fall_done", done, 1);
        sweep();
        check("fall_ch2_trig", g2[4], 50); check("fall_ch1_trig", g1[4], 6);
        check("fall_ch1_old", g1[0], 2); check("fall_ch2_pre", g2[3], 200); check("fall_ch2_post", g2[5], 30);

        // crossing during PRE must be ignored
        setup(0, 0, 0);
        drive(1, 0, 0, 1);
        k = 0;
        do begin
            drive(1, k == 0 ? -5 : k == 1 ? 5 : k == 2 ? 6 : k == 3 ? 7 : k == 4 ? -3 : k == 5 ? 3 : 10, k, 0);
            k++;
        end while (!m_done && k < 200);
        check("pre_ign_pos", m_k, 5);
        sweep();
        check("pre_ign_trig", g1[4], 3); check("pre_ign_before", g1[3], -3);
        check("pre_ign_old", g1[0], 5); check("pre_ign_last", g1[15], 10);

        // gapped valid: only even cycles carry samples
        setup(0, 0, 0);
        drive(1, 0, 0, 1);
        k = 0;
        do begin drive(k % 2 == 0, -8 + k, k, 0); k++; end while (!m_done && k < 200);
        check("gap_done", done, 1);
        sweep();
        check("gap_trig", g1[4], 0); check("gap_old", g1[0], -8); check("gap_last", g1[15], 22);

        // reset in the middle of POST
        setup(0, 0, 0);
        drive(1, -9, 0, 1);
        k = 0;
        do begin drive(1, -8 + k, k, 0); k++; end while (!(m_k >= 0 && q1.size() > m_k + 3) && k < 200);
        check("mid_post_busy", busy, 1);
        @(negedge clk_in); #2 rst_n = 0;
        #1 check("async_busy", busy, 0); check("async_done", done, 0); check("async_rd1", rd1, 0);
        repeat (3) @(negedge clk_in);
        check("rst_hold_done", done, 0);
        #2 rst_n = 1;
        ramp_capture();

        // randomized captures, stray arms while busy
        for (int r = 0; r < 10; r++) begin
            int n = 0;
            setup($urandom_range(0, 1), $urandom_range(0, 1), int'($urandom_range(0, 20)) - 10);
            drive(1, 0, 0, 1);
            do begin
                drive($urandom_range(0, 3) != 0, int'($urandom_range(0, 40)) - 20,
                      int'($urandom_range(0, 40)) - 20, $urandom_range(0, 15) == 0);
                n++;
            end while (!m_done && n < 3000);
            check("rand_done", done, 1);
            sweep();
        end

        // constant input: only a timeout can end WAIT
        setup(0, 0, 0);
        drive(1, 7, 7, 1);
        k = 0;
`ifdef AD_TRIG_AUTO_EN
        do begin drive(1, 7, 7, 0); k++; end while (!m_done && k < 200);
        check("auto_pos", m_k, PRE + ATO - 1);
        check("auto_done", done, 1); check("auto_flag", auto_trig, 1);
        sweep();
        drive(1, 7, 7, 1);
        drive(1, 7, 7, 0);
        check("auto_clear", auto_trig, 0);
`else
        do begin drive(1, 7, 7, 0); k++; end while (k < 100);
        check("noauto_busy", busy, 1); check("noauto_done", done, 0);
`endif
        @(negedge clk_in); #2 rst_n = 0;
        #5 $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ad_trig_capture.md
Name: ad_trig_capture

Overview:
- Downstream consumer of the dual-channel AD9226 front end.
- Takes the two signed 12-bit offset-corrected sample streams and watches one selected channel for a level-crossing trigger.
- Stores a pre/post-trigger window of both channels in a circular buffer and exposes it through a random-access read port for the display/readout logic.
- Provides the oscilloscope-style single-shot capture for the instrument.

Parameters:
- DW, 12, sample width (two's complement)
- AW, 10, buffer address width; window depth N = 2^AW samples per channel
- PRE_DEPTH, 256, samples stored before the trigger sample; legal range 1..N-1
- AUTO_TIMEOUT, 65535, samples in WAIT before a forced trigger (used only with the optional feature)

Ports:
- clk_in  in  1  sample clock, same clock as the ADC front end
- rst_n  in  1  asynchronous active-low reset
- sample_ch1  in  DW  signed channel-1 sample
- sample_ch2  in  DW  signed channel-2 sample
- sample_valid  in  1  qualifies sample_ch1/ch2 this cycle
- arm  in  1  one-cycle pulse that starts a capture
- trig_sel  in  1  trigger source: 0 = ch1, 1 = ch2
- trig_edge  in  1  0 = rising, 1 = falling
- trig_level  in  DW  signed trigger threshold
- busy  out  1  high in PRE, WAIT and POST
- done  out  1  high in DONE
- auto_trig  out  1  last trigger was forced by timeout
- rd_addr  in  AW  window-relative read index; 0 = oldest sample
- rd_data_ch1  out  DW  ch1 sample at rd_addr
- rd_data_ch2  out  DW  ch2 sample at rd_addr
- trig_index  out  AW  window-relative index of the trigger sample, always PRE_DEPTH

Behaviour:
Interface:
- Reset rst_n, asynchronous, active-low; clock clk_in.
- Reset state: FSM = IDLE; wr_ptr, counters and prev-sample register = 0; busy = done = auto_trig = 0; rd_data_ch1/ch2 = 0.

Buffer and sampling:
- Buffer is two N x DW RAMs (inferred).
- Writes occur only when sample_valid = 1 and state is PRE, WAIT or POST.
- wr_ptr increments per write and wraps N-1 -> 0.

Trigger compare:
- Signed compare of the selected channel against trig_level.
- Rising edge: prev < level AND cur >= level.
- Falling edge: prev > level AND cur <= level.
- prev is the previous valid sample of the selected channel in the current capture.
- No trigger is possible on the first valid sample after arm.

FSM:
- IDLE: arm -> PRE; clear pre counter and prev_ok.
- PRE: count valid writes; after PRE_DEPTH writes -> WAIT. Trigger crossings in PRE are ignored.
- WAIT: each valid sample is written and compared.
  - On a crossing, the crossing sample is the trigger sample: latch trig_addr = wr_ptr of that write, load post counter = N - PRE_DEPTH - 1, go to POST.
  - If N - PRE_DEPTH - 1 = 0, go directly to DONE.
- POST: count down on each valid write; at 0 after the last write -> DONE. The window then holds exactly N samples.
- DONE: done = 1; buffer is frozen. arm -> PRE for a new capture, overwriting the buffer.

Status outputs:
- busy = 1 in PRE, WAIT and POST; done = 1 in DONE. Both update the cycle after the state change (registered).
- arm while busy is ignored; capture is single-shot only.
- trig_sel, trig_edge and trig_level are sampled live. They must be held stable while busy; changes take effect on the next compare.

Readout:
- Physical address = (trig_addr - PRE_DEPTH + rd_addr) mod N.
- rd_data is registered, 1-cycle latency from rd_addr.
- Readout is valid only in DONE; contents are undefined otherwise.

Reset mid-capture:
- Immediate return to IDLE; done = 0.
- Buffer contents are not cleared.

Optional Feature:
- Macro AD_TRIG_AUTO_EN.
- Defined:
  - A WAIT-state counter counts valid samples.
  - When it reaches AUTO_TIMEOUT without a crossing, the current sample is treated as the trigger and auto_trig = 1.
  - auto_trig is cleared on the next arm.
- Not defined:
  - No counter is built; WAIT lasts indefinitely.
  - auto_trig is tied to 0.

Test Plan:
- Reset/idle (AW=4, PRE_DEPTH=4): hold sample_valid = 1 with a ramp and no arm -> busy = done = 0, no writes. rst_n low at any time -> outputs 0 asynchronously.
- Rising trigger (AW=4, PRE=4, level=0, ch1 ramp -8,-7,... one per cycle, arm) -> trigger on sample 0. After 11 more samples done = 1. Reading rd_addr 0..15 gives -4..11; rd_addr 4 gives 0; 1-cycle read latency.
- Falling trigger on ch2 (trig_sel=1, trig_edge=1, level=100, ch2 = 200 then 50) -> trigger on the sample 50; ch1 data captured alongside at the same indices.
- Crossing during PRE ignored: crossing at the 2nd valid sample after arm -> no trigger. The next crossing after 4 writes triggers; the window is aligned to that second crossing.
- Gapped valid (sample_valid toggling 1010...) -> only valid samples are stored; post count is unaffected by invalid cycles. Reset asserted mid-POST -> IDLE, done stays 0. A fresh arm then completes normally.
- AD_TRIG_AUTO_EN with AUTO_TIMEOUT=20 and a constant input -> forced trigger after 20 WAIT samples, auto_trig = 1, done after 11 more samples. Without the macro, the same stimulus -> busy stays 1 indefinitely.
